ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 11 +
 rtl/rr_arb2.sv | 34 +++
 rtl/ram_arbiter.sv | 90 +++++++++
 tb/tb_ram_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-requester RAM arbiter.
package ram_arbiter_pkg;

    localparam int NUM_REQ       = 2;
    localparam int DEF_RAM_WIDTH = 8;
    localparam int DEF_RAM_DEPTH = 16;
    localparam int DEF_ADDR_SIZE = 4;

    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past each winner.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  req_vec_t req,
    output req_vec_t gnt
);

    logic prio_p0;

    always_comb begin
        gnt = '0;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio_p0 ? 2'b10 : 2'b01;
                default: gnt = '0;
            endcase
        end
    end

    // After a grant, favour whichever requester did not win.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_p0 <= 1'b0;
        end else if (|gnt) begin
            prio_p0 <= gnt[0];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two write and two read requesters onto one 1-cycle dual-port RAM,
// with optional same-cycle write-to-read forwarding.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int BYPASS    = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             wr_req,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   wr_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]   wr_data,
    output logic [NUM_REQ-1:0]             wr_gnt,
    input  logic [NUM_REQ-1:0]             rd_req,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   rd_addr,
    output logic [NUM_REQ-1:0]             rd_gnt,
    output logic [NUM_REQ-1:0]             rd_valid,
    output logic [RAM_WIDTH-1:0]           rd_data,
    output logic                           ram_write,
    output logic                           ram_read,
    output logic [ADDR_SIZE-1:0]           ram_wr_addr,
    output logic [ADDR_SIZE-1:0]           ram_rd_addr,
    output logic [RAM_WIDTH-1:0]           ram_data_in,
    input  logic [RAM_WIDTH-1:0]           ram_data_out
);

    if (RAM_DEPTH > (1 << ADDR_SIZE)) begin : g_depth_chk
        $error("RAM_DEPTH exceeds the range of ADDR_SIZE");
    end

    logic                 collide_p0;
    logic [NUM_REQ-1:0]   rd_vld_p1;
    logic                 byp_vld_p1;
    logic [RAM_WIDTH-1:0] byp_data_p1;

    // p0: arbitration and RAM command
    rr_arb2 u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    always_comb begin
        ram_wr_addr = wr_addr[0 +: ADDR_SIZE];
        ram_data_in = wr_data[0 +: RAM_WIDTH];
        ram_rd_addr = rd_addr[0 +: ADDR_SIZE];
        if (wr_gnt[1]) begin
            ram_wr_addr = wr_addr[ADDR_SIZE +: ADDR_SIZE];
            ram_data_in = wr_data[RAM_WIDTH +: RAM_WIDTH];
        end
        if (rd_gnt[1]) begin
            ram_rd_addr = rd_addr[ADDR_SIZE +: ADDR_SIZE];
        end
    end

    assign ram_write  = |wr_gnt;
    assign ram_read   = |rd_gnt;
    assign collide_p0 = (BYPASS != 0) && ram_write && ram_read && (ram_wr_addr == ram_rd_addr);

    // p1: read return, RAM data or forwarded write data
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p1   <= '0;
            byp_vld_p1  <= 1'b0;
            byp_data_p1 <= '0;
        end else begin
            rd_vld_p1  <= rd_gnt;
            byp_vld_p1 <= collide_p0;
            if (collide_p0) begin
                byp_data_p1 <= ram_data_in;
            end
        end
    end

    // Gating with reset drops a read that was granted just before reset rose.
    assign rd_valid = reset ? '0 : rd_vld_p1;
    assign rd_data  = byp_vld_p1 ? byp_data_p1 : ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Random and directed bench for ram_arbiter; one instance per BYPASS setting,
// each with its own read-before-write RAM, against a reference model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_req, rd_req;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;

    logic [1:0] b_wr_gnt, b_rd_gnt, b_rd_valid, n_wr_gnt, n_rd_gnt, n_rd_valid;
    logic [7:0] b_rd_data, n_rd_data, b_ram_din, n_ram_din, b_ram_dout, n_ram_dout;
    logic [3:0] b_ram_wa, b_ram_ra, n_ram_wa, n_ram_ra;
    logic       b_ram_write, b_ram_read, n_ram_write, n_ram_read;

    logic [7:0] mem_b [16];
    logic [7:0] mem_n [16];
    logic [7:0] ref_mem [16];

    int n_cmp = 0;
    int n_mis = 0;

    int         wr_last, rd_last;
    logic [1:0] pend_vld, last_wg;
    logic [7:0] exp_b, exp_n;
    logic [1:0] obs_wg, obs_rg, obs_rv;
    logic [7:0] obs_rdb, obs_rdn;
    logic [1:0] seq_wg [4];
    logic [1:0] seq_rv [4];
    logic [7:0] seq_rd [4];

    always #5 clk = ~clk;

    ram_arbiter #(.RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_SIZE(4), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(b_wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(b_rd_gnt), .rd_valid(b_rd_valid),
        .rd_data(b_rd_data), .ram_write(b_ram_write), .ram_read(b_ram_read),
        .ram_wr_addr(b_ram_wa), .ram_rd_addr(b_ram_ra), .ram_data_in(b_ram_din),
        .ram_data_out(b_ram_dout)
    );

    ram_arbiter #(.RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_SIZE(4), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(n_wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(n_rd_gnt), .rd_valid(n_rd_valid),
        .rd_data(n_rd_data), .ram_write(n_ram_write), .ram_read(n_ram_read),
        .ram_wr_addr(n_ram_wa), .ram_rd_addr(n_ram_ra), .ram_data_in(n_ram_din),
        .ram_data_out(n_ram_dout)
    );

    // Read-before-write RAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (b_ram_read)  b_ram_dout <= mem_b[b_ram_ra];
        if (b_ram_write) mem_b[b_ram_wa] <= b_ram_din;
        if (n_ram_read)  n_ram_dout <= mem_n[n_ram_ra];
        if (n_ram_write) mem_n[n_ram_wa] <= n_ram_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Single active requester wins; with both, the one not granted last wins.
    function automatic logic [1:0] pick(input logic [1:0] req, input int last);
        if (req == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return req;
    endfunction

    task automatic tick();
        logic [1:0] ewg, erg;
        int         wk, rk;
        logic [3:0] wa, ra;
        logic [7:0] wd;
        @(negedge clk);
        ewg = reset ? 2'b00 : pick(wr_req, wr_last);
        erg = reset ? 2'b00 : pick(rd_req, rd_last);
        wk  = ewg[1] ? 1 : 0;
        rk  = erg[1] ? 1 : 0;
        wa  = wr_addr[wk*4 +: 4];
        wd  = wr_data[wk*8 +: 8];
        ra  = rd_addr[rk*4 +: 4];
        obs_wg = b_wr_gnt; obs_rg = b_rd_gnt; obs_rv = b_rd_valid;
        obs_rdb = b_rd_data; obs_rdn = n_rd_data;
        chk("wr_gnt", 32'(b_wr_gnt), 32'(ewg));
        chk("wr_gnt_nb", 32'(n_wr_gnt), 32'(ewg));
        chk("rd_gnt", 32'(b_rd_gnt), 32'(erg));
        chk("rd_gnt_nb", 32'(n_rd_gnt), 32'(erg));
        chk("ram_write", 32'(b_ram_write), 32'(ewg != 2'b00));
        chk("ram_read", 32'(b_ram_read), 32'(erg != 2'b00));
        chk("rd_valid", 32'(b_rd_valid), 32'(reset ? 2'b00 : pend_vld));
        chk("rd_valid_nb", 32'(n_rd_valid), 32'(reset ? 2'b00 : pend_vld));
        if (!reset && pend_vld != 2'b00) begin
            chk("rd_data", 32'(b_rd_data), 32'(exp_b));
            chk("rd_data_nb", 32'(n_rd_data), 32'(exp_n));
        end
        if (ewg != 2'b00) begin
            chk("ram_wr_addr", 32'(b_ram_wa), 32'(wa));
            chk("ram_data_in", 32'(b_ram_din), 32'(wd));
        end
        if (erg != 2'b00) chk("ram_rd_addr", 32'(b_ram_ra), 32'(ra));
        if (reset) begin
            wr_last = 1; rd_last = 1; pend_vld = 2'b00;
        end else begin
            pend_vld = erg;
            if (erg != 2'b00) begin
                exp_b = ref_mem[ra];
                exp_n = ref_mem[ra];
                rd_last = rk;
            end
            if (ewg != 2'b00) begin
                if (erg != 2'b00 && wa == ra) exp_b = wd;
                ref_mem[wa] = wd;
                wr_last = wk;
            end
        end
        last_wg = ewg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_b[i] = 8'h00; mem_n[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        wr_last = 1; rd_last = 1; pend_vld = 2'b00; last_wg = 2'b00;
        exp_b = 8'h00; exp_n = 8'h00;

        // Reset with everything requesting: no grants, no RAM activity
        reset = 1'b1; wr_req = 2'b11; rd_req = 2'b11;
        wr_addr = 8'h21; wr_data = 16'h1234; rd_addr = 8'h43;
        tick(); tick();
        chk("reset_wr_gnt", 32'(obs_wg), 32'd0);
        chk("reset_rd_gnt", 32'(obs_rg), 32'd0);
        reset = 1'b0; rd_req = 2'b00;

        // Contending writers alternate starting with requester 0
        for (int i = 0; i < 4; i++) begin
            tick();
            seq_wg[i] = obs_wg;
        end
        chk("rr_w0", 32'(seq_wg[0]), 32'h1);
        chk("rr_w1", 32'(seq_wg[1]), 32'h2);
        chk("rr_w2", 32'(seq_wg[2]), 32'h1);
        chk("rr_w3", 32'(seq_wg[3]), 32'h2);

        // Write A5 to 3, read it back through requester 1
        wr_req = 2'b01; wr_addr = 8'h03; wr_data = 16'h00A5;
        tick();
        chk("basic_wgnt", 32'(obs_wg), 32'h1);
        wr_req = 2'b00; rd_req = 2'b10; rd_addr = 8'h30;
        tick();
        chk("basic_rgnt", 32'(obs_rg), 32'h2);
        rd_req = 2'b00;
        tick();
        chk("basic_rvld", 32'(obs_rv), 32'h2);
        chk("basic_rdata", 32'(obs_rdb), 32'hA5);

        // Back-to-back alternating reads of 5 and 6
        wr_req = 2'b11; wr_addr = 8'h65; wr_data = 16'h6655;
        tick(); tick();
        wr_req = 2'b00; rd_req = 2'b11; rd_addr = 8'h65;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rd_req = 2'b00;
            tick();
            seq_rv[i] = obs_rv;
            seq_rd[i] = obs_rdb;
        end
        for (int i = 0; i < 4; i++) begin
            chk("b2b_rvld", 32'(seq_rv[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("b2b_rdata", 32'(seq_rd[i]), (i % 2 == 0) ? 32'h55 : 32'h66);
        end

        // Same-cycle write/read collision on address 7
        wr_req = 2'b01; wr_addr = 8'h07; wr_data = 16'h0011;
        tick();
        wr_data = 16'h003C; rd_req = 2'b01; rd_addr = 8'h07;
        tick();
        wr_req = 2'b00; rd_req = 2'b00;
        tick();
        chk("coll_rvld", 32'(obs_rv), 32'h1);
        chk("coll_bypass", 32'(obs_rdb), 32'h3C);
        chk("coll_nobypass", 32'(obs_rdn), 32'h11);

        // Reset right after a read grant kills the return and re-arms priority
        rd_req = 2'b01; rd_addr = 8'h03;
        tick();
        rd_req = 2'b00; reset = 1'b1; wr_req = 2'b11; wr_addr = 8'h98; wr_data = 16'hBBAA;
        tick();
        chk("rst_rvld", 32'(obs_rv), 32'h0);
        chk("rst_wgnt", 32'(obs_wg), 32'h0);
        chk("rst_rgnt", 32'(obs_rg), 32'h0);
        reset = 1'b0;
        tick();
        chk("rst_prio", 32'(obs_wg), 32'h1);
        wr_req = 2'b00;
        tick();

        // Random traffic; requesters hold until granted
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(wr_req[k] && !last_wg[k])) begin
                    wr_req[k]         = ($urandom_range(0, 2) != 0);
                    wr_addr[k*4 +: 4] = 4'($urandom_range(0, 3));
                    wr_data[k*8 +: 8] = 8'($urandom);
                end
                if (!(rd_req[k] && !obs_rg[k])) begin
                    rd_req[k]         = ($urandom_range(0, 2) != 0);
                    rd_addr[k*4 +: 4] = 4'($urandom_range(0, 3));
                end
            end
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
